// File: rtl/csr_file_param_pkg.sv
// Shared definitions for the machine-mode CSR file.
// Holds the CSR addresses, csr_ctrl encodings, trap cause codes, WARL masks,
// FSM states, and the read-modify-write helper used for CSR writes.
package csr_file_param_pkg;

    localparam int unsigned CSR_ADDR_W = 12;

    // CSR addresses
    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
    localparam logic [CSR_ADDR_W-1:0] CSR_MARCHID   = 12'hF12;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIMPID    = 12'hF13;
    localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

    // csr_ctrl encodings
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Redirect FSM
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } csr_state_e;

    // Cause codes (exceptions and interrupt numbers share the 4-bit field)
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;
    localparam logic [3:0] IRQ_MSI          = 4'd3;
    localparam logic [3:0] IRQ_MTI          = 4'd7;
    localparam logic [3:0] IRQ_MEI          = 4'd11;

    // WARL masks and fixed fields
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIP_MSIP_BIT     = 3;
    localparam logic [63:0] MSTATUS_MPP_M    = 64'h0000_0000_0000_1800;
    localparam logic [63:0] MIE_WMASK        = 64'h0000_0000_0000_0888;
    localparam logic [63:0] PC_ALIGN_MASK    = ~64'h3;
    localparam logic [8:0]  MISA_EXT_I       = 9'h100;

    // New CSR value for a read-modify-write operation
    function automatic logic [63:0] csr_apply(input csr_op_e op,
                                              input logic [63:0] old_val,
                                              input logic [63:0] operand);
        logic [63:0] res;
        res = old_val;
        case (op)
            CSR_OP_RW: res = operand;
            CSR_OP_RS: res = old_val | operand;
            CSR_OP_RC: res = old_val & ~operand;
            default:   res = old_val;
        endcase
        return res;
    endfunction

    function automatic logic csr_is_implemented(input logic [CSR_ADDR_W-1:0] idx);
        logic hit;
        case (idx)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MVENDORID,
            CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: hit = 1'b1;
            default:                               hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic csr_is_read_only(input logic [CSR_ADDR_W-1:0] idx);
        logic ro;
        case (idx)
            CSR_MISA, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: ro = 1'b1;
            default:                                                       ro = 1'b0;
        endcase
        return ro;
    endfunction

endpackage

// File: rtl/csr_file_param_counter.sv
// csr_counter: free-running counter with a CSR write port.
// Ports: clk, rst (async active-low), inc (count enable), wr_en/wr_data
// (load, takes precedence over inc), value (current count).
module csr_counter #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    output logic [CNT_W-1:0] value
);

    // A write in the same cycle replaces the increment; the add wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (wr_en) begin
            value <= wr_data;
        end else if (inc) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/csr_file_param.sv
// csr_file_param: machine-mode CSR file with trap entry / mret and a
// fetch-redirect handshake.
// Ports:
//   clk, rst (async active-low)
//   inst_valid, csr_index, csr_ctrl, csr_wdata : retiring CSR instruction
//   inst_addr, inst_next_pc                    : PC / next PC of that instruction
//   inst_ecall, inst_ebreak, inst_mret         : retiring-instruction flags
//   irq_msip, irq_mtip, irq_meip               : level interrupt lines
//   redirect_ack                               : fetch accepted the redirect
//   csr_read (comb from csr_index), csr_illegal (comb)
//   redirect_valid, redirect_pc                : pending fetch redirect
module csr_file_param
    import csr_file_param_pkg::*;
#(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     CNT_W       = 64,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid,
    input  logic [CSR_ADDR_W-1:0] csr_index,
    input  logic [1:0]            csr_ctrl,
    input  logic [XLEN-1:0]       csr_wdata,
    input  logic [XLEN-1:0]       inst_addr,
    input  logic [XLEN-1:0]       inst_next_pc,
    input  logic                  inst_ecall,
    input  logic                  inst_ebreak,
    input  logic                  inst_mret,
    input  logic                  irq_msip,
    input  logic                  irq_mtip,
    input  logic                  irq_meip,
    input  logic                  redirect_ack,
    output logic [XLEN-1:0]       csr_read,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  csr_illegal
);

    localparam logic [1:0]      MXL        = (XLEN == 64) ? 2'd2 : 2'd1;
    localparam logic [XLEN-1:0] MISA_VAL   = {MXL, (XLEN-2)'(MISA_EXT_I)};
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(PC_ALIGN_MASK);

    csr_state_e state, state_next;

    logic [XLEN-1:0]  mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic             st_mie, st_mpie;
    logic             msip_sw, msip_ext, mtip_s, meip_s;
    logic [CNT_W-1:0] mcycle_val, minstret_val;

    logic [XLEN-1:0]  mstatus_val, mip_val, wval;
    logic [XLEN-1:0]  tvec_base, trap_epc, trap_cause, redirect_target;
    logic [11:0]      irq_pend;
    logic [3:0]       irq_cause, exc_cause;
    logic             fire, take_exc, take_irq, take_trap, take_mret, wr_en;
    csr_op_e          op;

    assign op = csr_op_e'(csr_ctrl);

    // Architectural views of the packed status/pending registers
    assign mstatus_val = XLEN'({2'b11, 3'b000, st_mpie, 3'b000, st_mie, 3'b000});
    assign mip_val     = XLEN'({meip_s, 3'b000, mtip_s, 3'b000, msip_sw | msip_ext, 3'b000});

    // Combinational read mux
    always_comb begin
        csr_read = '0;
        case (csr_index)
            CSR_MSTATUS:  csr_read = mstatus_val;
            CSR_MISA:     csr_read = MISA_VAL;
            CSR_MIE:      csr_read = mie_q;
            CSR_MTVEC:    csr_read = mtvec_q;
            CSR_MSCRATCH: csr_read = mscratch_q;
            CSR_MEPC:     csr_read = mepc_q;
            CSR_MCAUSE:   csr_read = mcause_q;
            CSR_MIP:      csr_read = mip_val;
            CSR_MCYCLE:   csr_read = XLEN'(mcycle_val);
            CSR_MINSTRET: csr_read = XLEN'(minstret_val);
            default:      csr_read = '0;
        endcase
    end

    assign csr_illegal = (op != CSR_OP_NONE) &&
                         (!csr_is_implemented(csr_index) || csr_is_read_only(csr_index));

    // Retirement / trap decision; exceptions beat interrupts, ecall beats ebreak
    assign fire      = (state == ST_IDLE) && inst_valid;
    assign irq_pend  = mie_q[11:0] & mip_val[11:0];
    assign take_exc  = fire && (inst_ecall || inst_ebreak);
    assign take_irq  = fire && st_mie && (irq_pend != 12'd0) && !take_exc;
    assign take_trap = take_exc || take_irq;
    assign take_mret = fire && inst_mret && !take_trap;
    assign wr_en     = fire && (op != CSR_OP_NONE) && !csr_illegal && !take_trap;

    assign wval = XLEN'(csr_apply(op, 64'(csr_read), 64'(csr_wdata)));

    assign exc_cause = inst_ecall ? CAUSE_ECALL_M : CAUSE_BREAKPOINT;
    assign irq_cause = irq_pend[11] ? IRQ_MEI :
                       irq_pend[3]  ? IRQ_MSI : IRQ_MTI;

    assign tvec_base  = mtvec_q & ALIGN_MASK;
    assign trap_epc   = take_exc ? inst_addr : inst_next_pc;
    assign trap_cause = take_exc ? XLEN'(exc_cause) : {1'b1, (XLEN-1)'(irq_cause)};

    // Vectored mode only applies to interrupts
    always_comb begin
        redirect_target = tvec_base;
        if (take_mret) begin
            redirect_target = mepc_q;
        end else if (take_irq && (mtvec_q[1:0] == 2'b01)) begin
            redirect_target = tvec_base + XLEN'({irq_cause, 2'b00});
        end
    end

    // CSR state: writes first, then mret, then trap entry take precedence
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            msip_sw    <= 1'b0;
            msip_ext   <= 1'b0;
            mtip_s     <= 1'b0;
            meip_s     <= 1'b0;
        end else begin
            msip_ext <= irq_msip;
            mtip_s   <= irq_mtip;
            meip_s   <= irq_meip;
            if (wr_en) begin
                case (csr_index)
                    CSR_MSTATUS: begin
                        st_mie  <= wval[MSTATUS_MIE_BIT];
                        st_mpie <= wval[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:      mie_q      <= wval & XLEN'(MIE_WMASK);
                    CSR_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
                    CSR_MSCRATCH: mscratch_q <= wval;
                    CSR_MEPC:     mepc_q     <= wval & ALIGN_MASK;
                    CSR_MCAUSE:   mcause_q   <= wval;
                    CSR_MIP:      msip_sw    <= wval[MIP_MSIP_BIT];
                    default: ;
                endcase
            end
            if (take_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
            if (take_trap) begin
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
                mepc_q   <= trap_epc & ALIGN_MASK;
                mcause_q <= trap_cause;
            end
        end
    end

    csr_counter #(.CNT_W(CNT_W)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .wr_en   (wr_en && (csr_index == CSR_MCYCLE)),
        .wr_data (CNT_W'(wval)),
        .value   (mcycle_val)
    );

    csr_counter #(.CNT_W(CNT_W)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc     (fire),
        .wr_en   (wr_en && (csr_index == CSR_MINSTRET)),
        .wr_data (CNT_W'(wval)),
        .value   (minstret_val)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (take_trap || take_mret) state_next = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ack)           state_next = ST_IDLE;
            default:                                 state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        redirect_valid = (state == ST_REDIRECT);
    end

    // Redirect target captured on entry and held until the ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_pc <= '0;
        end else if (take_trap || take_mret) begin
            redirect_pc <= redirect_target;
        end
    end

endmodule

// File: tb/tb_csr_file_param.sv
// Testbench for csr_file_param: directed scenarios followed by random traffic,
// all checked against a behavioural CSR model. A second 32-bit instance covers
// counter wrap at CNT_W=32.
module tb_csr_file_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        inst_valid, inst_ecall, inst_ebreak, inst_mret;
    logic [11:0] csr_index;
    logic [1:0]  csr_ctrl;
    logic [63:0] csr_wdata, inst_addr, inst_next_pc;
    logic        irq_msip, irq_mtip, irq_meip, redirect_ack;
    logic [63:0] csr_read, redirect_pc;
    logic        redirect_valid, csr_illegal;

    csr_file_param #(.XLEN(64), .CNT_W(64), .RESET_MTVEC(64'h100)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .csr_index(csr_index),
        .csr_ctrl(csr_ctrl), .csr_wdata(csr_wdata), .inst_addr(inst_addr),
        .inst_next_pc(inst_next_pc), .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak),
        .inst_mret(inst_mret), .irq_msip(irq_msip), .irq_mtip(irq_mtip),
        .irq_meip(irq_meip), .redirect_ack(redirect_ack), .csr_read(csr_read),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .csr_illegal(csr_illegal)
    );

    // 32-bit instance
    logic        d2_valid;
    logic [11:0] d2_index;
    logic [1:0]  d2_ctrl;
    logic [31:0] d2_wdata, d2_read, d2_rpc;
    logic        d2_rvalid, d2_illegal;

    csr_file_param #(.XLEN(32), .CNT_W(32), .RESET_MTVEC(32'h0)) dut32 (
        .clk(clk), .rst(rst), .inst_valid(d2_valid), .csr_index(d2_index),
        .csr_ctrl(d2_ctrl), .csr_wdata(d2_wdata), .inst_addr(32'h0),
        .inst_next_pc(32'h4), .inst_ecall(1'b0), .inst_ebreak(1'b0),
        .inst_mret(1'b0), .irq_msip(1'b0), .irq_mtip(1'b0),
        .irq_meip(1'b0), .redirect_ack(1'b0), .csr_read(d2_read),
        .redirect_valid(d2_rvalid), .redirect_pc(d2_rpc), .csr_illegal(d2_illegal)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] idx_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h344, 12'hB00, 12'hB02, 12'hF11, 12'hF12,
                                  12'hF13, 12'hF14, 12'h7C0, 12'hB80};

    // Behavioural model state
    logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret, m_rpc;
    logic        m_st_mie, m_st_mpie, m_msip_sw, m_msip_ext, m_mtip, m_meip, m_redir;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mtvec = 64'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_mcycle = 0; m_minstret = 0; m_rpc = 0;
        m_st_mie = 0; m_st_mpie = 0; m_msip_sw = 0; m_msip_ext = 0;
        m_mtip = 0; m_meip = 0; m_redir = 0;
    endtask

    function automatic logic [63:0] m_mip();
        return (64'(m_meip) << 11) | (64'(m_mtip) << 7) | (64'(m_msip_sw | m_msip_ext) << 3);
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] i);
        case (i)
            12'h300: return 64'h1800 | (64'(m_st_mpie) << 7) | (64'(m_st_mie) << 3);
            12'h301: return 64'h8000_0000_0000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
            12'hB00: return m_mcycle;
            12'hB02: return m_minstret;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic m_illegal(input logic [1:0] c, input logic [11:0] i);
        logic known, ro;
        known = 1'b0;
        for (int k = 0; k < 14; k++) if (idx_tab[k] == i) known = 1'b1;
        ro = (i == 12'h301) || (i >= 12'hF11 && i <= 12'hF14);
        return (c != 2'b00) && (!known || ro);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        logic        fire, exc, irq, trap, mr, wr, old_mie, old_mpie;
        logic [63:0] pend, old, nv, base, tgt;
        logic [3:0]  cause;
        fire = !m_redir && inst_valid;
        exc  = fire && (inst_ecall || inst_ebreak);
        pend = m_mie & m_mip();
        irq  = fire && m_st_mie && (pend != 0) && !exc;
        trap = exc || irq;
        mr   = fire && inst_mret && !trap;
        wr   = fire && (csr_ctrl != 2'b00) && !m_illegal(csr_ctrl, csr_index) && !trap;
        old  = m_read(csr_index);
        case (csr_ctrl)
            2'b01:   nv = csr_wdata;
            2'b10:   nv = old | csr_wdata;
            default: nv = old & ~csr_wdata;
        endcase
        cause = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
        base  = m_mtvec & ~64'h3;
        if (mr) tgt = m_mepc;
        else if (irq && m_mtvec[1:0] == 2'b01) tgt = base + 64'(cause) * 4;
        else tgt = base;
        old_mie = m_st_mie; old_mpie = m_st_mpie;

        m_mcycle = m_mcycle + 1;
        if (fire) m_minstret = m_minstret + 1;
        if (wr) begin
            case (csr_index)
                12'h300: begin m_st_mie = nv[3]; m_st_mpie = nv[7]; end
                12'h304: m_mie = nv & 64'h888;
                12'h305: m_mtvec = (nv[1:0] >= 2'd2) ? (nv & ~64'h3) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~64'h3;
                12'h342: m_mcause = nv;
                12'h344: m_msip_sw = nv[3];
                12'hB00: m_mcycle = nv;
                12'hB02: m_minstret = nv;
                default: ;
            endcase
        end
        if (mr) begin m_st_mie = old_mpie; m_st_mpie = 1'b1; end
        if (trap) begin
            m_st_mpie = old_mie; m_st_mie = 1'b0;
            m_mepc   = (exc ? inst_addr : inst_next_pc) & ~64'h3;
            m_mcause = exc ? (inst_ecall ? 64'd11 : 64'd3) : ({1'b1, 63'd0} | 64'(cause));
        end
        if (m_redir) begin
            if (redirect_ack) m_redir = 1'b0;
        end else if (trap || mr) begin
            m_redir = 1'b1; m_rpc = tgt;
        end
        m_msip_ext = irq_msip; m_mtip = irq_mtip; m_meip = irq_meip;
    endtask

    // One cycle: check comb outputs, clock, check registered outputs
    task automatic step();
        #1;
        chk("csr_read", csr_read, m_read(csr_index));
        chk("csr_illegal", 64'(csr_illegal), 64'(m_illegal(csr_ctrl, csr_index)));
        model_step();
        @(posedge clk); #1;
        chk("redirect_valid", 64'(redirect_valid), 64'(m_redir));
        chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic peek(input string tag, input logic [11:0] i, input logic [63:0] exp);
        csr_index = i; csr_ctrl = 2'b00; inst_valid = 1'b0;
        #1;
        chk(tag, csr_read, exp);
    endtask

    task automatic clr();
        inst_valid = 0; csr_ctrl = 0; csr_wdata = 0;
        inst_ecall = 0; inst_ebreak = 0; inst_mret = 0;
    endtask

    task automatic csr_op(input logic [1:0] c, input logic [11:0] i, input logic [63:0] d);
        clr(); inst_valid = 1; csr_ctrl = c; csr_index = i; csr_wdata = d;
        step();
        clr();
    endtask

    task automatic ack();
        clr(); redirect_ack = 1; step(); redirect_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] mc0, mi0;

    initial begin
        rst = 0; clr(); csr_index = 0; inst_addr = 0; inst_next_pc = 4;
        irq_msip = 0; irq_mtip = 0; irq_meip = 0; redirect_ack = 0;
        d2_valid = 0; d2_index = 0; d2_ctrl = 0; d2_wdata = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 64'(redirect_valid), 64'h0);
        chk("rst_rpc", redirect_pc, 64'h0);
        peek("rst_mstatus", 12'h300, 64'h1800);
        peek("rst_mtvec", 12'h305, 64'h100);
        peek("rst_mcycle", 12'hB00, 64'h0);
        peek("misa", 12'h301, 64'h8000_0000_0000_0100);
        peek("mhartid", 12'hF14, 64'h0);
        peek("unimpl_read", 12'h7C0, 64'h0);
        @(posedge clk); #1;
        rst = 1; model_reset();

        // RS mstatus with 0xFFFF
        clr(); inst_valid = 1; csr_ctrl = 2'b10; csr_index = 12'h300; csr_wdata = 64'hFFFF;
        #1 chk("rs_mstatus_illegal", 64'(csr_illegal), 64'h0);
        step(); clr();
        peek("rs_mstatus", 12'h300, 64'h1888);

        // Illegal writes leave state alone
        clr(); inst_valid = 1; csr_ctrl = 2'b01; csr_index = 12'h301; csr_wdata = 64'h0;
        #1 chk("misa_wr_illegal", 64'(csr_illegal), 64'h1);
        step();
        clr(); inst_valid = 1; csr_ctrl = 2'b10; csr_index = 12'h7C0; csr_wdata = 64'h1;
        #1 chk("unimpl_illegal", 64'(csr_illegal), 64'h1);
        step();
        clr(); inst_valid = 1; csr_index = 12'h301;
        #1 chk("misa_noop_legal", 64'(csr_illegal), 64'h0);
        step(); clr();
        peek("misa_kept", 12'h301, 64'h8000_0000_0000_0100);

        // Vectored timer interrupt
        csr_op(2'b01, 12'h305, 64'h1001);
        csr_op(2'b01, 12'h304, 64'h80);
        irq_mtip = 1; clr(); step();
        clr(); inst_valid = 1; inst_addr = 64'h2000; inst_next_pc = 64'h2004;
        step(); clr();
        chk("mti_rvalid", 64'(redirect_valid), 64'h1);
        chk("mti_rpc", redirect_pc, 64'h101C);
        peek("mti_mcause", 12'h342, 64'h8000_0000_0000_0007);
        peek("mti_mepc", 12'h341, 64'h2004);
        peek("mti_mstatus", 12'h300, 64'h1880);

        // Held in REDIRECT: inst_valid ignored
        irq_mtip = 0;
        mc0 = m_mcycle; mi0 = m_minstret;
        for (int i = 0; i < 5; i++) begin
            clr(); inst_valid = (i % 2 == 0); csr_ctrl = 2'b01; csr_index = 12'h340;
            csr_wdata = 64'hDEAD; inst_ecall = (i == 2);
            step();
            chk("hold_rpc", redirect_pc, 64'h101C);
        end
        clr();
        peek("hold_mcycle", 12'hB00, mc0 + 5);
        peek("hold_minstret", 12'hB02, mi0);
        peek("hold_mscratch", 12'h340, 64'h0);
        ack();

        // mret
        clr(); inst_valid = 1; inst_mret = 1; step(); clr();
        chk("mret_rpc", redirect_pc, 64'h2004);
        peek("mret_mstatus", 12'h300, 64'h1888);
        ack();

        // ecall together with external interrupt
        csr_op(2'b01, 12'h304, 64'hFFFF);
        irq_meip = 1; clr(); step();
        clr(); inst_valid = 1; inst_ecall = 1; inst_addr = 64'h3000; inst_next_pc = 64'h3004;
        step(); clr();
        chk("ecall_rpc", redirect_pc, 64'h1000);
        peek("ecall_mcause", 12'h342, 64'd11);
        peek("ecall_mepc", 12'h341, 64'h3000);
        irq_meip = 0; ack();

        // ebreak
        clr(); inst_valid = 1; inst_ebreak = 1; inst_addr = 64'h4000; step(); clr();
        chk("ebreak_rpc", redirect_pc, 64'h1000);
        peek("ebreak_mcause", 12'h342, 64'd3);
        ack();

        // Vectored external interrupt
        csr_op(2'b10, 12'h300, 64'h8);
        irq_meip = 1; clr(); step();
        clr(); inst_valid = 1; inst_next_pc = 64'h5008; step(); clr();
        chk("mei_rpc", redirect_pc, 64'h102C);
        peek("mei_mcause", 12'h342, 64'h8000_0000_0000_000B);
        irq_meip = 0; ack();

        // MSI beats MTI
        csr_op(2'b10, 12'h300, 64'h8);
        irq_msip = 1; irq_mtip = 1; clr(); step();
        clr(); inst_valid = 1; inst_next_pc = 64'h6000; step(); clr();
        chk("msi_rpc", redirect_pc, 64'h100C);
        peek("msi_mcause", 12'h342, 64'h8000_0000_0000_0003);
        irq_msip = 0; irq_mtip = 0; ack();

        // WARL fields and counter write override
        csr_op(2'b01, 12'h341, 64'h1237);
        peek("mepc_warl", 12'h341, 64'h1234);
        csr_op(2'b01, 12'h305, 64'h2003);
        peek("mtvec_warl", 12'h305, 64'h2000);
        csr_op(2'b01, 12'h344, 64'hFFFF);
        peek("mip_warl", 12'h344, 64'h8);
        csr_op(2'b11, 12'h344, 64'h8);
        peek("mip_rc", 12'h344, 64'h0);
        csr_op(2'b01, 12'hB02, 64'h50);
        peek("minstret_override", 12'hB02, 64'h50);
        csr_op(2'b01, 12'hB00, 64'h1000);
        peek("mcycle_write", 12'hB00, 64'h1000);

        // Reset in the middle of a redirect
        clr(); inst_valid = 1; inst_ecall = 1; inst_addr = 64'h7000; step(); clr();
        chk("pre_rst_rvalid", 64'(redirect_valid), 64'h1);
        #2 rst = 0;
        #1;
        chk("midrst_rvalid", 64'(redirect_valid), 64'h0);
        chk("midrst_rpc", redirect_pc, 64'h0);
        peek("midrst_mstatus", 12'h300, 64'h1800);
        peek("midrst_mtvec", 12'h305, 64'h100);
        peek("midrst_mepc", 12'h341, 64'h0);
        peek("midrst_mcause", 12'h342, 64'h0);
        peek("midrst_mie", 12'h304, 64'h0);
        peek("midrst_mcycle", 12'hB00, 64'h0);
        peek("midrst_minstret", 12'hB02, 64'h0);
        @(posedge clk); #1;
        rst = 1; model_reset(); redirect_ack = 0; clr();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            clr();
            inst_valid = ($urandom % 4) != 0;
            csr_index = idx_tab[$urandom % 16];
            r = $urandom % 16;
            if (r == 0) inst_ecall = 1;
            else if (r == 1) inst_ebreak = 1;
            else if (r == 2) begin inst_ecall = 1; inst_ebreak = 1; end
            else if (r == 3) inst_mret = 1;
            else begin
                csr_ctrl  = 2'($urandom);
                csr_wdata = {$urandom, $urandom};
            end
            inst_addr    = {$urandom, $urandom} & ~64'h3;
            inst_next_pc = inst_addr + 64'h4;
            irq_msip = ($urandom % 8) == 0;
            irq_mtip = ($urandom % 8) == 0;
            irq_meip = ($urandom % 8) == 0;
            redirect_ack = $urandom % 2;
            step();
        end
        clr(); redirect_ack = 0; irq_msip = 0; irq_mtip = 0; irq_meip = 0;

        // 32-bit counters wrap
        d2_valid = 1; d2_ctrl = 2'b01; d2_index = 12'hB00; d2_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        d2_valid = 0; d2_ctrl = 2'b00; #1;
        chk("c32_mcycle_max", 64'(d2_read), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("c32_mcycle_wrap", 64'(d2_read), 64'h0);
        d2_valid = 1; d2_ctrl = 2'b01; d2_index = 12'hB02; d2_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        d2_ctrl = 2'b00; #1;
        chk("c32_minstret_max", 64'(d2_read), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("c32_minstret_wrap", 64'(d2_read), 64'h0);
        d2_valid = 0; d2_index = 12'h301; #1;
        chk("c32_misa", 64'(d2_read), 64'h4000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_file_param.md
CSR_FILE_PARAM -- requirements
Module: csr_file_param

Interface
REQ-001 SHALL have parameter XLEN, default 64: data/address width, 32 or 64.
REQ-002 SHALL have parameter CNT_W, default 64: mcycle/minstret width, 32..XLEN.
REQ-003 SHALL have parameter RESET_MTVEC, default 0: mtvec reset value.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 inst_valid  in  1  instruction retires this cycle.
REQ-007 csr_index  in  12  CSR address.
REQ-008 csr_ctrl  in  2  encoding: 00 none, 01 RW, 10 RS, 11 RC.
REQ-009 csr_wdata  in  XLEN  write operand, rs1 or imm already selected.
REQ-010 inst_addr / inst_next_pc  in  XLEN each  PC and sequential next PC of the retiring instruction.
REQ-011 inst_ecall, inst_ebreak, inst_mret  in  1 each  retiring-instruction flags.
REQ-012 irq_msip, irq_mtip, irq_meip  in  1 each  level interrupt lines.
REQ-013 redirect_ack  in  1  fetch accepted redirect.
REQ-014 csr_read  out  XLEN  read data; redirect_valid  out  1; redirect_pc  out  XLEN; csr_illegal  out  1.

Function
REQ-015 csr_read SHALL be combinational from csr_index. Implemented CSRs are mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mip, mcycle, minstret, mvendorid, marchid, mimpid, mhartid. Unimplemented indices read 0.
REQ-016 Write value: RW=wdata, RS=old|wdata, RC=old&~wdata. A write commits only when inst_valid=1, csr_ctrl!=00, FSM is IDLE, and csr_illegal=0.
REQ-017 csr_illegal=1 when csr_ctrl!=00 and either the index is unimplemented or the index is read-only (misa, mvendorid, marchid, mimpid, mhartid). No state changes in that case.
REQ-018 WARL masks:
- mstatus: writable bits MIE[3] and MPIE[7] only; MPP[12:11] reads 11.
- mie: writable bits 3, 7, 11 only.
- mip: software-writable bit 3 (MSIP) only. Bit 7 mirrors irq_mtip and bit 11 mirrors irq_meip, sampled each cycle.
- mtvec: writes with MODE[1:0]>=2 store MODE=0.
- mepc: bits [1:0] are forced to 0.
REQ-019 mcycle SHALL increment every cycle. minstret SHALL increment on each inst_valid in IDLE. Both wrap modulo 2^CNT_W, read zero-extended, written truncated to CNT_W. A CSR write to a counter in the same cycle overrides its increment.
REQ-020 Interrupt take condition: IDLE && inst_valid && mstatus.MIE && (mie & mip)!=0. Priority MEI(11) > MSI(3) > MTI(7).
REQ-021 Exception take condition: IDLE && inst_valid && (ecall | ebreak). The exception has priority over an interrupt in the same cycle; ecall > ebreak.
REQ-022 On a trap, at the same edge:
- mepc = inst_addr (exception) or inst_next_pc (interrupt).
- mcause = 11 / 3 for exceptions, or {1, cause} for interrupts.
- MPIE = MIE, MIE = 0.
- The retiring instruction's CSR write is suppressed.
REQ-023 On mret in IDLE with inst_valid and no trap: MIE = MPIE, MPIE = 1.
REQ-024 FSM states IDLE and REDIRECT. IDLE->REDIRECT on trap or mret. REDIRECT->IDLE on redirect_ack.
REQ-025 redirect_valid=1 exactly in REDIRECT. redirect_pc SHALL be registered on entry and held stable until the ack.
REQ-026 redirect_pc values:
- mret: mepc.
- Exception, or mtvec.MODE=0: {mtvec[XLEN-1:2],00}.
- Vectored interrupt: base + 4*cause.
REQ-027 In REDIRECT, inst_valid SHALL be ignored: no CSR write, no minstret increment, no new trap. An ack arriving in the entry cycle is not possible because redirect_valid is not yet high.
REQ-028 misa SHALL read MXL (1 for XLEN=32, 2 for XLEN=64) plus the I extension bit. mvendorid, marchid, mimpid and mhartid read 0.

Reset
REQ-029 While rst=0, asynchronously:
- FSM = IDLE, redirect_valid = 0, redirect_pc = 0.
- mstatus = 0x1800; mie, mip.MSIP, mscratch, mepc, mcause and both counters = 0; mtvec = RESET_MTVEC.
REQ-030 Reset asserted in REDIRECT SHALL drop redirect_valid immediately, and the pending redirect is lost.

Structure
REQ-031 CSR index constants, csr_ctrl encodings, cause codes, WARL masks and the FSM state enum SHALL live in the shared defines package.
REQ-032 One sub-module, csr_counter (parameter CNT_W; inputs inc, wr_en, wr_data), SHALL be instantiated for mcycle and for minstret.

Verification
REQ-033 Scenario: RS to mstatus with wdata=0xFFFF. Required: mstatus reads 0x1888; csr_illegal=0.
REQ-034 Scenario: mtvec=0x1001, mie=0x80, MIE=1, irq_mtip=1, inst_valid with inst_next_pc=0x2004. Required: next cycle redirect_valid=1, redirect_pc=0x101C, mcause=0x8000_0000_0000_0007, mepc=0x2004.
REQ-035 Scenario: ecall and irq_meip in the same cycle. Required: mcause=11, redirect_pc=0x1000, mepc=inst_addr.
REQ-036 Scenario: hold redirect_ack=0 for 5 cycles while pulsing inst_valid. Required: redirect_pc stable, minstret unchanged, mcycle +5.
REQ-037 Scenario: CNT_W=32, write mcycle=0xFFFF_FFFF. Required: next read is 0.
REQ-038 Scenario: assert rst mid-REDIRECT. Required: redirect_valid=0 immediately, and all reset values per REQ-029.
